// File: rtl/pcpi_dispatch.sv
// pcpi_dispatch
// -----------------------------------------------------------------------------
// Request-side front end for the PCPI coprocessors. Each M-extension
// instruction offered by picorv32 is decoded once. Its opcode and operands are
// latched, and a registered valid is driven to exactly one unit: the
// multiplier or the divider. That valid is held until the selected unit
// completes. The block then drains until the CPU withdraws its request, so a
// single CPU request can never be dispatched twice.
//
// Optional feature (compile-time macro PCPI_WATCHDOG_EN):
//   When defined, a BUSY-cycle counter of width $clog2(TIMEOUT_CYCLES) is built.
//   If the selected unit has not completed after TIMEOUT_CYCLES cycles, the
//   counter aborts the unit and pulses timeout_err for one cycle.
//   When undefined, no counter exists, timeout_err is tied low, and BUSY waits
//   indefinitely for ready or a CPU abort.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles before the watchdog fires (2..1023)
//
// Ports:
//   clk              system clock, all state on the rising edge
//   resetn           asynchronous active-low reset
//   pcpi_valid       CPU request, held until ready or abort
//   pcpi_insn        instruction word
//   pcpi_rs1         operand 1
//   pcpi_rs2         operand 2
//   pcpi_mul_ready   multiplier completion strobe
//   pcpi_div_ready   divider completion strobe
//   pcpi_mul_valid   registered request to the multiplier
//   pcpi_div_valid   registered request to the divider
//   pcpi_insn_out    captured instruction
//   pcpi_rs1_out     captured operand 1
//   pcpi_rs2_out     captured operand 2
//   busy             high while a request is in flight or draining
//   timeout_err      one-cycle pulse when the watchdog expires
// -----------------------------------------------------------------------------
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    input  logic        pcpi_mul_ready,
    input  logic        pcpi_div_ready,
    output logic        pcpi_mul_valid,
    output logic        pcpi_div_valid,
    output logic [31:0] pcpi_insn_out,
    output logic [31:0] pcpi_rs1_out,
    output logic [31:0] pcpi_rs2_out,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   is_m_insn;
    logic   accept;
    logic   sel_ready;
    logic   expire;
    logic   timeout_d;

    assign is_m_insn = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign accept    = (state_q == IDLE) && pcpi_valid && is_m_insn;

    // Only the unit we dispatched to may complete us; the other strobe is noise.
    assign sel_ready = sel_q ? pcpi_div_ready : pcpi_mul_ready;

`ifdef PCPI_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    assign expire = (state_q == BUSY) && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // The counter restarts on each acceptance. It advances only on BUSY cycles
    // that stay in BUSY. Because expiry leaves BUSY, the counter never has to
    // count past TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= '0;
        end else if ((state_q == BUSY) && pcpi_valid && !sel_ready) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next state. Within BUSY, a CPU abort beats completion, and completion
    // beats watchdog expiry, so a ready on the expiry edge never reports an
    // error.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    sel_d   = pcpi_insn[14];
                end
            end
            BUSY: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else if (sel_ready) begin
                    state_d = DRAIN;
                end else if (expire) begin
                    state_d   = DRAIN;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The unit valids and busy are decoded from the next state and then
    // registered. They therefore come straight from flops and line up exactly
    // with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            sel_q          <= 1'b0;
            pcpi_mul_valid <= 1'b0;
            pcpi_div_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            pcpi_mul_valid <= (state_d == BUSY) && !sel_d;
            pcpi_div_valid <= (state_d == BUSY) && sel_d;
            busy           <= (state_d != IDLE);
        end
    end

    // Captured request fields change only when a new instruction is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcpi_insn_out <= '0;
            pcpi_rs1_out  <= '0;
            pcpi_rs2_out  <= '0;
        end else if (accept) begin
            pcpi_insn_out <= pcpi_insn;
            pcpi_rs1_out  <= pcpi_rs1;
            pcpi_rs2_out  <= pcpi_rs2;
        end
    end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// tb_pcpi_dispatch
// -----------------------------------------------------------------------------
// Directed bench for pcpi_dispatch (TIMEOUT_CYCLES = 8).
//
// When the stimulus issues an M-extension request, it queues the dispatch it
// expects to see. A monitor process watches for the rising edge of either unit
// valid, pops the queue, and compares the captured instruction, the operands,
// and the selected unit. Cycle-level behaviour is checked inline by the
// stimulus. This covers valid drop after ready, drain, abort, the watchdog,
// and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pcpi_dispatch;

    localparam logic [31:0] INSN_MUL = 32'h02B50533;
    localparam logic [31:0] INSN_DIV = 32'h02B54533;
    localparam logic [31:0] INSN_ADD = 32'h00B50533;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_mul_ready;
    logic        pcpi_div_ready;
    logic        pcpi_mul_valid;
    logic        pcpi_div_valid;
    logic [31:0] pcpi_insn_out;
    logic [31:0] pcpi_rs1_out;
    logic [31:0] pcpi_rs2_out;
    logic        busy;
    logic        timeout_err;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        is_div;
    } exp_t;

    exp_t exp_q[$];
    int   pass_count = 0;
    int   total_count = 0;
    bit   expect_timeout = 1'b0;

    pcpi_dispatch #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pcpi_valid    (pcpi_valid),
        .pcpi_insn     (pcpi_insn),
        .pcpi_rs1      (pcpi_rs1),
        .pcpi_rs2      (pcpi_rs2),
        .pcpi_mul_ready(pcpi_mul_ready),
        .pcpi_div_ready(pcpi_div_ready),
        .pcpi_mul_valid(pcpi_mul_valid),
        .pcpi_div_valid(pcpi_div_valid),
        .pcpi_insn_out (pcpi_insn_out),
        .pcpi_rs1_out  (pcpi_rs1_out),
        .pcpi_rs2_out  (pcpi_rs2_out),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Issues a request on the current (negative) edge and queues the dispatch
    // that should follow, if the instruction is an M-extension op.
    task automatic apply_stimulus(input logic [31:0] insn, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input bit expect_dispatch);
        exp_t e;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        pcpi_valid = 1'b1;
        if (expect_dispatch) begin
            e.insn   = insn;
            e.rs1    = rs1;
            e.rs2    = rs2;
            e.is_div = insn[14];
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: compares each new dispatch against the scoreboard and flags any
    // watchdog pulse that the stimulus did not ask for.
    initial begin : monitor
        logic prev_disp;
        logic cur_disp;
        exp_t e;
        prev_disp = 1'b0;
        forever begin
            @(negedge clk);
            cur_disp = pcpi_mul_valid | pcpi_div_valid;
            if (cur_disp && !prev_disp) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_dispatch", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_insn", pcpi_insn_out, e.insn);
                    check_output("sb_rs1", pcpi_rs1_out, e.rs1);
                    check_output("sb_rs2", pcpi_rs2_out, e.rs2);
                    check_output("sb_div_valid", {31'd0, pcpi_div_valid}, {31'd0, e.is_div});
                    check_output("sb_mul_valid", {31'd0, pcpi_mul_valid}, {31'd0, !e.is_div});
                end
            end
            if (timeout_err && !expect_timeout) begin
                check_output("unexpected_timeout", 32'd1, 32'd0);
            end
            prev_disp = cur_disp;
        end
    end

    initial begin : sim_guard
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL sim_timeout: bench did not finish within 5000 cycles");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : stimulus
        resetn         = 1'b0;
        pcpi_valid     = 1'b0;
        pcpi_insn      = '0;
        pcpi_rs1       = '0;
        pcpi_rs2       = '0;
        pcpi_mul_ready = 1'b0;
        pcpi_div_ready = 1'b0;

        // Reset state
        step();
        step();
        check_output("rst_mul_valid", {31'd0, pcpi_mul_valid}, 32'd0);
        check_output("rst_div_valid", {31'd0, pcpi_div_valid}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_insn_out", pcpi_insn_out, 32'd0);
        check_output("rst_timeout", {31'd0, timeout_err}, 32'd0);
        resetn = 1'b1;
        step();

        $display("[TB] MUL dispatch");
        apply_stimulus(INSN_MUL, 32'd7, 32'd6, 1'b1);
        step();
        check_output("mul_valid", {31'd0, pcpi_mul_valid}, 32'd1);
        check_output("mul_div_valid", {31'd0, pcpi_div_valid}, 32'd0);
        check_output("mul_rs1", pcpi_rs1_out, 32'd7);
        check_output("mul_rs2", pcpi_rs2_out, 32'd6);
        check_output("mul_busy", {31'd0, busy}, 32'd1);
        step();
        check_output("mul_hold", {31'd0, pcpi_mul_valid}, 32'd1);
        pcpi_mul_ready = 1'b1;
        step();
        pcpi_mul_ready = 1'b0;
        check_output("mul_valid_drop", {31'd0, pcpi_mul_valid}, 32'd0);
        check_output("mul_drain_busy", {31'd0, busy}, 32'd1);
        pcpi_valid = 1'b0;
        step();
        check_output("mul_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] DIV dispatch with stray mul_ready");
        apply_stimulus(INSN_DIV, 32'd100, 32'd7, 1'b1);
        step();
        check_output("div_valid", {31'd0, pcpi_div_valid}, 32'd1);
        pcpi_mul_ready = 1'b1;
        step();
        pcpi_mul_ready = 1'b0;
        check_output("div_stray_ignored", {31'd0, pcpi_div_valid}, 32'd1);
        check_output("div_stray_busy", {31'd0, busy}, 32'd1);
        pcpi_div_ready = 1'b1;
        step();
        pcpi_div_ready = 1'b0;
        check_output("div_valid_drop", {31'd0, pcpi_div_valid}, 32'd0);
        // The CPU is slow to drop its request; DRAIN must not re-dispatch.
        step();
        step();
        check_output("div_drain_busy", {31'd0, busy}, 32'd1);
        check_output("div_drain_no_valid", {31'd0, pcpi_div_valid | pcpi_mul_valid}, 32'd0);
        pcpi_valid = 1'b0;
        step();
        check_output("div_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] Non-M instruction");
        apply_stimulus(INSN_ADD, 32'h55, 32'hAA, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (pcpi_mul_valid || pcpi_div_valid || busy) begin
                check_output("add_no_dispatch", 32'd1, 32'd0);
            end
        end
        check_output("add_busy", {31'd0, busy}, 32'd0);
        check_output("add_insn_kept", pcpi_insn_out, INSN_DIV);
        check_output("add_rs1_kept", pcpi_rs1_out, 32'd100);
        check_output("add_rs2_kept", pcpi_rs2_out, 32'd7);
        pcpi_valid = 1'b0;
        step();

        $display("[TB] CPU abort on third BUSY cycle");
        apply_stimulus(INSN_MUL, 32'd3, 32'd4, 1'b1);
        step();
        step();
        step();
        pcpi_valid = 1'b0;
        step();
        check_output("abort_valid", {31'd0, pcpi_mul_valid}, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_timeout", {31'd0, timeout_err}, 32'd0);
        step();

`ifdef PCPI_WATCHDOG_EN
        $display("[TB] Watchdog expiry");
        apply_stimulus(INSN_MUL, 32'd21, 32'd22, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_output("wd_valid_high", {31'd0, pcpi_mul_valid}, 32'd1);
            check_output("wd_no_err_yet", {31'd0, timeout_err}, 32'd0);
        end
        expect_timeout = 1'b1;
        step();
        check_output("wd_valid_low", {31'd0, pcpi_mul_valid}, 32'd0);
        check_output("wd_err_pulse", {31'd0, timeout_err}, 32'd1);
        check_output("wd_busy", {31'd0, busy}, 32'd1);
        step();
        expect_timeout = 1'b0;
        check_output("wd_err_one_cycle", {31'd0, timeout_err}, 32'd0);
        check_output("wd_busy_held", {31'd0, busy}, 32'd1);
        pcpi_valid = 1'b0;
        step();
        check_output("wd_idle_busy", {31'd0, busy}, 32'd0);
`else
        $display("[TB] No watchdog: BUSY waits for ready");
        apply_stimulus(INSN_MUL, 32'd21, 32'd22, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            check_output("nowd_valid_high", {31'd0, pcpi_mul_valid}, 32'd1);
            check_output("nowd_no_err", {31'd0, timeout_err}, 32'd0);
        end
        pcpi_mul_ready = 1'b1;
        step();
        pcpi_mul_ready = 1'b0;
        check_output("nowd_valid_low", {31'd0, pcpi_mul_valid}, 32'd0);
        pcpi_valid = 1'b0;
        step();
        check_output("nowd_idle_busy", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] Ready on the expiry edge");
        apply_stimulus(INSN_DIV, 32'd40, 32'd5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_output("wdr_valid_high", {31'd0, pcpi_div_valid}, 32'd1);
            if (i == 7) pcpi_div_ready = 1'b1;
        end
        step();
        pcpi_div_ready = 1'b0;
        check_output("wdr_valid_low", {31'd0, pcpi_div_valid}, 32'd0);
        check_output("wdr_no_err", {31'd0, timeout_err}, 32'd0);
        check_output("wdr_busy", {31'd0, busy}, 32'd1);
        pcpi_valid = 1'b0;
        step();
        check_output("wdr_idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] Asynchronous reset mid-BUSY");
        apply_stimulus(INSN_MUL, 32'd9, 32'd9, 1'b1);
        step();
        check_output("rstm_valid_before", {31'd0, pcpi_mul_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_output("rstm_mul_valid", {31'd0, pcpi_mul_valid}, 32'd0);
        check_output("rstm_busy", {31'd0, busy}, 32'd0);
        check_output("rstm_insn", pcpi_insn_out, 32'd0);
        check_output("rstm_rs1", pcpi_rs1_out, 32'd0);
        check_output("rstm_rs2", pcpi_rs2_out, 32'd0);
        pcpi_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        apply_stimulus(INSN_MUL, 32'd11, 32'd13, 1'b1);
        step();
        check_output("post_rst_valid", {31'd0, pcpi_mul_valid}, 32'd1);
        check_output("post_rst_rs1", pcpi_rs1_out, 32'd11);
        pcpi_mul_ready = 1'b1;
        step();
        pcpi_mul_ready = 1'b0;
        check_output("post_rst_drop", {31'd0, pcpi_mul_valid}, 32'd0);
        pcpi_valid = 1'b0;
        step();
        check_output("post_rst_idle", {31'd0, busy}, 32'd0);

        step();
        step();
        check_output("sb_all_dispatched", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/pcpi_dispatch.md
# pcpi_dispatch

Request-side companion to the PCPI response merge. Decodes each PCPI instruction from picorv32, registers opcode and operands, and drives a per-unit valid to exactly one coprocessor (multiplier or divider). It holds that valid until the selected unit completes, then drains until the CPU drops its request, so the same instruction is never dispatched twice. An optional watchdog aborts a unit that never completes.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 64: cycles in BUSY before the watchdog fires. Legal range is 2..1023; used only with `PCPI_WATCHDOG_EN`.

**Ports**
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous active-low.
- `pcpi_valid`  in  1  CPU request; held high until the CPU sees ready or aborts.
- `pcpi_insn`  in  32  instruction word.
- `pcpi_rs1`  in  32  operand 1.
- `pcpi_rs2`  in  32  operand 2.
- `pcpi_mul_ready`  in  1  multiplier completion strobe.
- `pcpi_div_ready`  in  1  divider completion strobe.
- `pcpi_mul_valid`  out  1  request to multiplier; registered.
- `pcpi_div_valid`  out  1  request to divider; registered.
- `pcpi_insn_out`  out  32  captured instruction; registered.
- `pcpi_rs1_out`  out  32  captured operand 1; registered.
- `pcpi_rs2_out`  out  32  captured operand 2; registered.
- `busy`  out  1  high in BUSY or DRAIN.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation

- **Decode (M-extension):**
  - Match when `insn[6:0]==7'b0110011` and `insn[31:25]==7'b0000001`.
  - `insn[14]==0` selects MUL; `insn[14]==1` selects DIV.
- **States:** IDLE, BUSY, DRAIN. A `sel` register (0 = MUL, 1 = DIV) records the target unit.
- **IDLE:**
  - On `pcpi_valid` with a decode match: capture insn/rs1/rs2, set `sel`, clear the counter, go to BUSY.
  - A non-matching instruction stays in IDLE; no valid is driven and outputs are unchanged.
- **BUSY:**
  - `pcpi_mul_valid = (sel==0)`, `pcpi_div_valid = (sel==1)`. Both are derived from registered state.
  - Selected unit ready → DRAIN.
  - The non-selected unit's ready is ignored.
  - `pcpi_valid` low (CPU abort) → IDLE, with no error.
  - Watchdog expiry → DRAIN, with `timeout_err` pulsed.
- **DRAIN:** unit valids are low. Return to IDLE on the first cycle `pcpi_valid` is sampled low.
- **Priority in BUSY**, in the same cycle: CPU abort > selected ready > watchdog expiry.
- **Captured registers** hold their value outside IDLE and update only on acceptance.

**Reset values:** all outputs 0, state IDLE, `sel` 0, counter 0.

## Timing

- Request accepted at edge N. Captured data and unit valid are high from cycle N+1, so dispatch latency is 1 cycle.
- Selected ready sampled high at edge M → unit valid low from cycle M+1.
- The CPU drops `pcpi_valid` no earlier than the cycle after ready. DRAIN absorbs any number of extra cycles.
- **Back-to-back requests:** after DRAIN sees `pcpi_valid` low at edge K, IDLE can accept at edge K+1 at the earliest. Minimum spacing between dispatches is 3 edges after ready.
- **Watchdog:**
  - The counter increments each BUSY cycle without ready.
  - Expiry occurs at the edge where the count equals `TIMEOUT_CYCLES-1`.
  - `timeout_err` is high for exactly the following cycle.
  - Ready sampled on the expiry edge wins, and no error is raised.
- **Asynchronous reset mid-transaction:** unit valids and `busy` drop immediately, without waiting for a clock edge.

## Configuration

**Macro `PCPI_WATCHDOG_EN`.**
- **Defined:** the watchdog counter (width `$clog2(TIMEOUT_CYCLES)`) and the BUSY→DRAIN timeout path are built.
- **Undefined:**
  - No counter is built.
  - `timeout_err` is tied to 0.
  - BUSY waits indefinitely for ready or a CPU abort.
  - All other behaviour is identical.

## Test plan

- **MUL dispatch:** insn 0x02B50533 (mul) with rs1=7, rs2=6 → from cycle N+1, `pcpi_mul_valid`=1, `pcpi_div_valid`=0, `pcpi_rs1_out`=7, `pcpi_rs2_out`=6, `busy`=1. Assert `pcpi_mul_ready` at M → valid=0 at M+1. Drop `pcpi_valid` at M+1 → IDLE, `busy`=0 at M+2.
- **DIV dispatch:** insn 0x02B54533 (div) → `pcpi_div_valid` only. A stray `pcpi_mul_ready` pulse in BUSY is ignored. `pcpi_div_ready` completes the transaction.
- **Non-M instruction:** insn 0x00B50533 (add) with `pcpi_valid` held for 20 cycles → no unit valid, `busy`=0, captured registers unchanged.
- **Watchdog expiry:** `TIMEOUT_CYCLES`=8, macro defined, no ready → unit valid high for 8 cycles, then `timeout_err` pulses exactly 1 cycle and `busy` stays 1 until `pcpi_valid` drops. Repeat with ready on the expiry edge → no error.
- **CPU abort:** drop `pcpi_valid` on the 3rd BUSY cycle → unit valid low next cycle, IDLE, no `timeout_err`.
- **Reset mid-BUSY:** assert `resetn`=0 between edges → `pcpi_mul_valid`, `busy` and the captured registers read 0 immediately. After release, a new mul dispatches normally.
